// File: rtl/cdb_pkg.sv
// Shared definitions for the common-data-bus arbiter: default widths,
// the registered broadcast record and a select-width helper.
package cdb_pkg;

    localparam int CDB_NUM_REQ = 4;
    localparam int CDB_TAG_W   = 6;
    localparam int CDB_DATA_W  = 32;
    localparam int SRC_W       = $clog2(CDB_NUM_REQ);

    // One broadcast on the bus: write enable for the register file plus payload.
    typedef struct packed {
        logic                  valid;
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] data;
    } cdb_bus_t;

    // Index width for n requesters, never narrower than one bit.
    function automatic int src_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purely combinational round-robin picker: scans req starting at ptr,
// ascending and wrapping, and returns a one-hot grant plus its index.
module rr_arbiter
    import cdb_pkg::*;
#(
    parameter  int NUM_REQ = CDB_NUM_REQ,
    localparam int IDX_W   = src_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    // Walk offsets from farthest to nearest so the nearest requester at or after ptr wins.
    always_comb begin
        logic [IDX_W-1:0] idx;
        gnt     = '0;
        gnt_idx = '0;
        idx     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin grant among functional-unit result
// producers, one registered broadcast stage driving the register-file write
// port and the wakeup bus. Flush blocks grants for the cycle it is high.
// Optional conflict counter is built when CDB_ARB_PERF_EN is defined.
// Bus record widths come from cdb_pkg; TAG_W/DATA_W must match those defaults.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter  int NUM_REQ = CDB_NUM_REQ,
    parameter  int TAG_W   = CDB_TAG_W,
    parameter  int DATA_W  = CDB_DATA_W,
    localparam int SEL_W   = src_width(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
`ifdef CDB_ARB_PERF_EN
    input  logic                      perf_clr,
    output logic [15:0]               perf_conflict_cnt,
`endif
    input  logic [NUM_REQ-1:0]        fu_valid,
    input  logic [NUM_REQ*TAG_W-1:0]  fu_tag,
    input  logic [NUM_REQ*DATA_W-1:0] fu_data,
    output logic [NUM_REQ-1:0]        fu_ready,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_data,
    output logic [SEL_W-1:0]          cdb_src
);

    logic [NUM_REQ-1:0] gnt;
    logic [SEL_W-1:0]   gnt_idx;
    logic               xfer;
    logic [TAG_W-1:0]   tag_arr  [NUM_REQ];
    logic [DATA_W-1:0]  data_arr [NUM_REQ];

    cdb_bus_t         bus_q, bus_d;
    logic [SEL_W-1:0] src_q, src_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

    // Unpack the per-requester payload lanes.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
        assign tag_arr[gi]  = fu_tag[gi*TAG_W +: TAG_W];
        assign data_arr[gi] = fu_data[gi*DATA_W +: DATA_W];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req     (fu_valid),
        .ptr     (rr_ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // A flush suppresses every grant; the CDB never backpressures otherwise.
    assign fu_ready = flush ? '0 : gnt;
    assign xfer     = |fu_ready;

    // Next broadcast: payload and source only move on a transfer, valid is one cycle wide.
    always_comb begin
        bus_d       = bus_q;
        bus_d.valid = xfer;
        src_d       = src_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer) begin
            bus_d.tag  = tag_arr[gnt_idx];
            bus_d.data = data_arr[gnt_idx];
            src_d      = gnt_idx;
            rr_ptr_d   = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + SEL_W'(1);
        end
    end

    // Output register stage and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_q    <= '0;
            src_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            bus_q    <= bus_d;
            src_q    <= src_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign cdb_valid = bus_q.valid;
    assign cdb_tag   = bus_q.tag;
    assign cdb_data  = bus_q.data;
    assign cdb_src   = src_q;

`ifdef CDB_ARB_PERF_EN
    logic [15:0] perf_cnt_q, perf_cnt_d;
    logic        conflict;

    // A conflict is any unflushed cycle where more than one unit is asking.
    assign conflict = !flush && ($countones(fu_valid) > 1);

    // Saturating conflict count; clear wins over increment.
    always_comb begin
        perf_cnt_d = perf_cnt_q;
        if (perf_clr) begin
            perf_cnt_d = '0;
        end else if (conflict && (perf_cnt_q != 16'hFFFF)) begin
            perf_cnt_d = perf_cnt_q + 16'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cnt_q <= '0;
        end else begin
            perf_cnt_q <= perf_cnt_d;
        end
    end

    assign perf_conflict_cnt = perf_cnt_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter with a distance-based round-robin model.
module tb_cdb_arbiter;

    localparam int N  = 4;
    localparam int TW = 6;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic [N-1:0]      fu_valid = '0;
    logic [N*TW-1:0]   fu_tag = '0;
    logic [N*DW-1:0]   fu_data = '0;
    logic [N-1:0]      fu_ready;
    logic              cdb_valid;
    logic [TW-1:0]     cdb_tag;
    logic [DW-1:0]     cdb_data;
    logic [1:0]        cdb_src;
`ifdef CDB_ARB_PERF_EN
    logic              perf_clr = 1'b0;
    logic [15:0]       perf_conflict_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    bit quiet = 1'b0;

    // Reference model state
    int            m_ptr;
    logic          m_valid;
    logic [TW-1:0] m_tag;
    logic [DW-1:0] m_data;
    int            m_src;
    int            m_cnt;

    cdb_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
`ifdef CDB_ARB_PERF_EN
        .perf_clr (perf_clr),
        .perf_conflict_cnt (perf_conflict_cnt),
`endif
        .fu_valid (fu_valid),
        .fu_tag   (fu_tag),
        .fu_data  (fu_data),
        .fu_ready (fu_ready),
        .cdb_valid(cdb_valid),
        .cdb_tag  (cdb_tag),
        .cdb_data (cdb_data),
        .cdb_src  (cdb_src)
    );

    always #5 clk = ~clk;

    // Winner = valid requester with the smallest forward distance from ptr.
    function automatic int ref_winner(input logic [N-1:0] v, input int ptr);
        int best = -1;
        int best_dist = N;
        for (int i = 0; i < N; i++) begin
            if (v[i] && (((i - ptr + N) % N) < best_dist)) begin
                best_dist = (i - ptr + N) % N;
                best = i;
            end
        end
        return best;
    endfunction

    function automatic logic [N-1:0] ref_ready();
        logic [N-1:0] r = '0;
        int w = ref_winner(fu_valid, m_ptr);
        if (!flush && w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_valid = 1'b0; m_tag = '0; m_data = '0; m_src = 0; m_cnt = 0;
    endtask

    // Advance one clock and the model with it; returns at posedge+1.
    task automatic tick();
        int w;
        bit conf;
        bit clr;
        w = flush ? -1 : ref_winner(fu_valid, m_ptr);
        conf = !flush && ($countones(fu_valid) > 1);
        clr = 1'b0;
`ifdef CDB_ARB_PERF_EN
        clr = perf_clr;
`endif
        @(posedge clk);
        if (w >= 0) begin
            m_valid = 1'b1;
            m_tag = fu_tag[w*TW +: TW];
            m_data = fu_data[w*DW +: DW];
            m_src = w;
            m_ptr = (w + 1) % N;
            if (!quiet) $display("xfer src=%0d tag=%0d data=%08h", w, m_tag, m_data);
        end else begin
            m_valid = 1'b0;
        end
        if (clr) m_cnt = 0;
        else if (conf && m_cnt < 65535) m_cnt++;
        #1;
    endtask

    task automatic set_lane(input int i, input logic [TW-1:0] t, input logic [DW-1:0] d);
        fu_tag[i*TW +: TW] = t;
        fu_data[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        fu_valid = '0;
        flush = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #10;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        n_cmp++; if (cdb_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", cdb_valid); end
        n_cmp++; if (cdb_tag !== '0) begin n_bad++; $display("FAIL reset_tag got=%0d exp=0", cdb_tag); end
        n_cmp++; if (cdb_data !== '0) begin n_bad++; $display("FAIL reset_data got=%h exp=0", cdb_data); end
        n_cmp++; if (cdb_src !== 2'd0) begin n_bad++; $display("FAIL reset_src got=%0d exp=0", cdb_src); end
        n_cmp++; if (fu_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready got=%b exp=0000", fu_ready); end
`ifdef CDB_ARB_PERF_EN
        n_cmp++; if (perf_conflict_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_perf got=%0d exp=0", perf_conflict_cnt); end
`endif
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        for (int i = 0; i < N; i++) set_lane(i, TW'($urandom), $urandom);
        set_lane(2, 6'd17, 32'hDEADBEEF);
        fu_valid = 4'b0100;
        #3;
        n_cmp++; if (fu_ready !== 4'b0100) begin n_bad++; $display("FAIL single_ready got=%b exp=0100", fu_ready); end
        tick();
        n_cmp++; if (cdb_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid got=%b exp=1", cdb_valid); end
        n_cmp++; if (cdb_tag !== 6'd17) begin n_bad++; $display("FAIL single_tag got=%0d exp=17", cdb_tag); end
        n_cmp++; if (cdb_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL single_data got=%h exp=deadbeef", cdb_data); end
        n_cmp++; if (cdb_src !== 2'd2) begin n_bad++; $display("FAIL single_src got=%0d exp=2", cdb_src); end
        fu_valid = 4'b1111;
        #3;
        n_cmp++; if (fu_ready !== 4'b1000) begin n_bad++; $display("FAIL single_ptr3 got=%b exp=1000", fu_ready); end
        fu_valid = 4'b0000;
        tick();
        n_cmp++; if (cdb_valid !== 1'b0) begin n_bad++; $display("FAIL idle_valid got=%b exp=0", cdb_valid); end
        n_cmp++; if (cdb_tag !== 6'd17 || cdb_src !== 2'd2) begin n_bad++; $display("FAIL idle_hold got tag=%0d src=%0d exp tag=17 src=2", cdb_tag, cdb_src); end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < N; i++) set_lane(i, TW'(10 + i), 32'hA000_0000 + i);
        fu_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            #3;
            n_cmp++; if (fu_ready !== 4'(1 << (c % N))) begin n_bad++; $display("FAIL rr_ready c=%0d got=%b exp=%b", c, fu_ready, 4'(1 << (c % N))); end
            tick();
            n_cmp++; if (cdb_valid !== 1'b1 || cdb_src !== 2'(c % N) || cdb_tag !== TW'(10 + c % N)) begin
                n_bad++; $display("FAIL rr_bus c=%0d got v=%b src=%0d tag=%0d exp v=1 src=%0d tag=%0d", c, cdb_valid, cdb_src, cdb_tag, c % N, 10 + c % N);
            end
        end
        fu_valid = '0;
    endtask

    task automatic test_wrap();
        fu_valid = 4'b0100;
        #3; tick();
        fu_valid = 4'b0011;
        #3;
        n_cmp++; if (fu_ready !== 4'b0001) begin n_bad++; $display("FAIL wrap_g0 got=%b exp=0001", fu_ready); end
        tick();
        n_cmp++; if (cdb_src !== 2'd0 || cdb_valid !== 1'b1) begin n_bad++; $display("FAIL wrap_src0 got src=%0d v=%b exp src=0 v=1", cdb_src, cdb_valid); end
        fu_valid = 4'b0010;
        #3;
        n_cmp++; if (fu_ready !== 4'b0010) begin n_bad++; $display("FAIL wrap_g1 got=%b exp=0010", fu_ready); end
        tick();
        n_cmp++; if (cdb_src !== 2'd1 || cdb_valid !== 1'b1) begin n_bad++; $display("FAIL wrap_src1 got src=%0d v=%b exp src=1 v=1", cdb_src, cdb_valid); end
        fu_valid = 4'b0000;
        #3; tick();
        n_cmp++; if (cdb_valid !== 1'b0) begin n_bad++; $display("FAIL wrap_idle got=%b exp=0", cdb_valid); end
    endtask

    task automatic test_flush();
        set_lane(2, 6'd33, 32'h0BAD_F00D);
        fu_valid = 4'b0100;
        #3; tick();
        fu_valid = 4'b1001;
        flush = 1'b1;
        #3;
        n_cmp++; if (fu_ready !== 4'b0000) begin n_bad++; $display("FAIL flush_ready got=%b exp=0000", fu_ready); end
        n_cmp++; if (cdb_valid !== 1'b1 || cdb_tag !== 6'd33) begin n_bad++; $display("FAIL flush_inflight got v=%b tag=%0d exp v=1 tag=33", cdb_valid, cdb_tag); end
        tick();
        n_cmp++; if (cdb_valid !== 1'b0 || cdb_src !== 2'd2) begin n_bad++; $display("FAIL flush_after got v=%b src=%0d exp v=0 src=2", cdb_valid, cdb_src); end
        flush = 1'b0;
        #3;
        n_cmp++; if (fu_ready !== 4'b1000) begin n_bad++; $display("FAIL flush_ptr got=%b exp=1000", fu_ready); end
        tick();
        n_cmp++; if (cdb_valid !== 1'b1 || cdb_src !== 2'd3) begin n_bad++; $display("FAIL flush_resume got v=%b src=%0d exp v=1 src=3", cdb_valid, cdb_src); end
        fu_valid = '0;
        #3; tick();
    endtask

    task automatic test_async_reset();
        set_lane(1, 6'h2A, 32'h1234_5678);
        fu_valid = 4'b0010;
        #3; tick();
        n_cmp++; if (cdb_valid !== 1'b1) begin n_bad++; $display("FAIL areset_pre got=%b exp=1", cdb_valid); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (cdb_valid !== 1'b0 || cdb_tag !== '0 || cdb_data !== '0 || cdb_src !== 2'd0) begin
            n_bad++; $display("FAIL areset_now got v=%b tag=%0d data=%h src=%0d exp all 0", cdb_valid, cdb_tag, cdb_data, cdb_src);
        end
        model_reset();
        fu_valid = 4'b1111;
        #2;
        rst_n = 1'b1;
        #1;
        n_cmp++; if (fu_ready !== 4'b0001) begin n_bad++; $display("FAIL areset_first got=%b exp=0001", fu_ready); end
        tick();
        n_cmp++; if (cdb_src !== 2'd0 || cdb_valid !== 1'b1) begin n_bad++; $display("FAIL areset_src got src=%0d v=%b exp src=0 v=1", cdb_src, cdb_valid); end
        fu_valid = '0;
        #3; tick();
    endtask

    task automatic test_random();
        logic [N-1:0] exp_r;
        int w;
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!fu_valid[i] && $urandom_range(0, 1) == 1) begin
                    fu_valid[i] = 1'b1;
                    set_lane(i, TW'($urandom), $urandom);
                end
            end
            flush = ($urandom_range(0, 9) == 0);
            #3;
            exp_r = ref_ready();
            n_cmp++; if (fu_ready !== exp_r) begin n_bad++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, fu_ready, exp_r); end
            w = flush ? -1 : ref_winner(fu_valid, m_ptr);
            tick();
            if (w >= 0) fu_valid[w] = 1'b0;
            n_cmp++; if (cdb_valid !== m_valid || cdb_tag !== m_tag || cdb_data !== m_data || cdb_src !== 2'(m_src)) begin
                n_bad++; $display("FAIL rand_bus c=%0d got v=%b tag=%0d data=%h src=%0d exp v=%b tag=%0d data=%h src=%0d",
                                  c, cdb_valid, cdb_tag, cdb_data, cdb_src, m_valid, m_tag, m_data, m_src);
            end
`ifdef CDB_ARB_PERF_EN
            n_cmp++; if (perf_conflict_cnt !== 16'(m_cnt)) begin n_bad++; $display("FAIL rand_perf c=%0d got=%0d exp=%0d", c, perf_conflict_cnt, m_cnt); end
`endif
        end
        fu_valid = '0;
        flush = 1'b0;
        #3; tick();
    endtask

`ifdef CDB_ARB_PERF_EN
    task automatic test_perf();
        perf_clr = 1'b1;
        #3; tick();
        perf_clr = 1'b0;
        n_cmp++; if (perf_conflict_cnt !== 16'd0) begin n_bad++; $display("FAIL perf_clr0 got=%0d exp=0", perf_conflict_cnt); end
        fu_valid = 4'b0110;
        for (int c = 0; c < 5; c++) begin #3; tick(); end
        n_cmp++; if (perf_conflict_cnt !== 16'd5) begin n_bad++; $display("FAIL perf_five got=%0d exp=5", perf_conflict_cnt); end
        perf_clr = 1'b1;
        #3; tick();
        perf_clr = 1'b0;
        n_cmp++; if (perf_conflict_cnt !== 16'd0) begin n_bad++; $display("FAIL perf_clr_prio got=%0d exp=0", perf_conflict_cnt); end
        fu_valid = 4'b0011;
        quiet = 1'b1;
        for (int c = 0; c < 65540; c++) begin #3; tick(); end
        quiet = 1'b0;
        n_cmp++; if (perf_conflict_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL perf_sat got=%h exp=ffff", perf_conflict_cnt); end
        fu_valid = '0;
        #3; tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_flush();
        test_async_reset();
        test_random();
`ifdef CDB_ARB_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
